// File: rtl/hex_pkg.sv
// hex_pkg: shared types and helpers for the axial hex walkers
package hex_pkg;
  localparam int COORD_W = 32;
  typedef struct packed {
    logic signed [COORD_W-1:0] q;
    logic signed [COORD_W-1:0] r;
    logic signed [COORD_W-1:0] s;
  } hex_axial_t;
  typedef enum logic {IDLE, RUN} walker_state_e;
  function automatic logic [31:0] hex_range_count(input logic [31:0] n);
    return 32'd3 * n * (n + 32'd1) + 32'd1;
  endfunction
endpackage

// File: rtl/hex_row_bounds.sv
// hex_row_bounds: dr range [lo, hi] of row dq inside a hex of radius n
module hex_row_bounds #(
  parameter int W = 18
) (
  input  logic signed [W-1:0] dq_i,
  input  logic signed [W-1:0] n_i,
  output logic signed [W-1:0] lo_o,
  output logic signed [W-1:0] hi_o
);
  logic signed [W-1:0] a, b;
  assign a = -dq_i - n_i;
  assign b = -dq_i + n_i;
  assign lo_o = (a > -n_i) ? a : -n_i;
  assign hi_o = (b < n_i) ? b : n_i;
endmodule

// File: rtl/hex_range_walker.sv
// hex_range_walker: streams every axial hex within a clamped radius of a centre, one per accepted beat
module hex_range_walker
  import hex_pkg::*;
#(
  parameter int COORD_W    = 32,
  parameter int RADIUS_W   = 16,
  parameter int MAX_RADIUS = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] center_q,
  input  logic signed [COORD_W-1:0] center_r,
  input  logic [RADIUS_W-1:0]       radius,
  input  logic                      abort,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [COORD_W-1:0] out_q,
  output logic signed [COORD_W-1:0] out_r,
  output logic signed [COORD_W-1:0] out_s,
  output logic                      out_first,
  output logic                      out_last,
  output logic [31:0]               out_index,
  output logic                      done
);
  localparam int D = RADIUS_W + 2;
  walker_state_e state_q, state_d;
  logic signed [D-1:0] n_q, n_d, dq_q, dq_d, dr_q, dr_d, hi_q, hi_d;
  logic signed [D-1:0] n_in, dq_nx, dr_nx, lo_nx, hi_nx;
  logic signed [COORD_W-1:0] cq_q, cq_d, cr_q, cr_d, oq_q, oq_d, or_q, or_d, os_q, os_d;
  logic valid_q, valid_d, first_q, first_d, last_q, last_d, done_q, done_d, xfer, last_nx;
  logic [31:0] idx_q, idx_d;
  assign n_in = (32'(radius) > 32'(MAX_RADIUS)) ? D'(MAX_RADIUS) : D'(radius);
  assign xfer = valid_q && out_ready;
  // hi_q is the end of the current row; stepping past it moves to the next dq
  assign dq_nx = (dr_q == hi_q) ? dq_q + D'(1) : dq_q;
  assign dr_nx = (dr_q == hi_q) ? lo_nx : dr_q + D'(1);
  assign last_nx = (dq_nx == n_q) && (dr_nx == hi_nx);
  hex_row_bounds #(.W(D)) u_bounds (
    .dq_i(dq_nx),
    .n_i (n_q),
    .lo_o(lo_nx),
    .hi_o(hi_nx)
  );
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    dq_d    = dq_q;
    dr_d    = dr_q;
    hi_d    = hi_q;
    cq_d    = cq_q;
    cr_d    = cr_q;
    oq_d    = oq_q;
    or_d    = or_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        n_d     = n_in;
        dq_d    = -n_in;
        dr_d    = '0;
        hi_d    = n_in;
        cq_d    = center_q;
        cr_d    = center_r;
        oq_d    = center_q - COORD_W'(n_in);
        or_d    = center_r;
        valid_d = 1'b1;
        first_d = 1'b1;
        last_d  = (n_in == '0);
        idx_d   = '0;
      end
    end else if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else if (xfer) begin
      if (last_q) begin
        state_d = IDLE;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end else begin
        dq_d    = dq_nx;
        dr_d    = dr_nx;
        hi_d    = hi_nx;
        oq_d    = cq_q + COORD_W'(dq_nx);
        or_d    = cr_q + COORD_W'(dr_nx);
        first_d = 1'b0;
        last_d  = last_nx;
        idx_d   = idx_q + 32'd1;
      end
    end
    os_d = -oq_d - or_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      dq_q    <= '0;
      dr_q    <= '0;
      hi_q    <= '0;
      cq_q    <= '0;
      cr_q    <= '0;
      oq_q    <= '0;
      or_q    <= '0;
      os_q    <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      dq_q    <= dq_d;
      dr_q    <= dr_d;
      hi_q    <= hi_d;
      cq_q    <= cq_d;
      cr_q    <= cr_d;
      oq_q    <= oq_d;
      or_q    <= or_d;
      os_q    <= os_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end
  assign busy      = (state_q == RUN);
  assign out_valid = valid_q;
  assign out_q     = oq_q;
  assign out_r     = or_q;
  assign out_s     = os_q;
  assign out_first = first_q;
  assign out_last  = last_q;
  assign out_index = idx_q;
  assign done      = done_q;
endmodule

// File: tb/tb_hex_range_walker.sv
// tb_hex_range_walker: table-driven walks plus abort and reset corner sequences
module tb_hex_range_walker;
  import hex_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, out_ready = 1'b0, sel_b = 1'b0;
  logic [31:0] center_q = '0, center_r = '0;
  logic [15:0] radius = '0;
  logic a_busy, a_valid, a_first, a_last, a_done, b_busy, b_valid, b_first, b_last, b_done;
  logic [31:0] a_q, a_r, a_s, a_idx, b_q, b_r, b_s, b_idx;
  logic m_busy, m_valid, m_first, m_last, m_done;
  logic [31:0] m_q, m_r, m_s, m_idx;
  int total = 0, bad = 0;
  logic [31:0] eq[$], er[$];

  always #5 clk = ~clk;

  hex_range_walker #(.COORD_W(32), .RADIUS_W(16), .MAX_RADIUS(1023)) dut_a (
    .clk(clk), .reset(reset), .start(start), .center_q(center_q), .center_r(center_r),
    .radius(radius), .abort(abort), .busy(a_busy), .out_valid(a_valid), .out_ready(out_ready),
    .out_q(a_q), .out_r(a_r), .out_s(a_s), .out_first(a_first), .out_last(a_last),
    .out_index(a_idx), .done(a_done)
  );
  hex_range_walker #(.COORD_W(32), .RADIUS_W(16), .MAX_RADIUS(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .center_q(center_q), .center_r(center_r),
    .radius(radius), .abort(abort), .busy(b_busy), .out_valid(b_valid), .out_ready(out_ready),
    .out_q(b_q), .out_r(b_r), .out_s(b_s), .out_first(b_first), .out_last(b_last),
    .out_index(b_idx), .done(b_done)
  );

  assign m_busy  = sel_b ? b_busy  : a_busy;
  assign m_valid = sel_b ? b_valid : a_valid;
  assign m_first = sel_b ? b_first : a_first;
  assign m_last  = sel_b ? b_last  : a_last;
  assign m_done  = sel_b ? b_done  : a_done;
  assign m_q     = sel_b ? b_q     : a_q;
  assign m_r     = sel_b ? b_r     : a_r;
  assign m_s     = sel_b ? b_s     : a_s;
  assign m_idx   = sel_b ? b_idx   : a_idx;

  typedef struct {
    int          rad;
    logic [31:0] cq, cr;
    int          pct;
    int          cnt;
    logic [31:0] fq, fr, lq, lr;
    bit          b;
  } vec_t;

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  function automatic void build(input int n, input logic [31:0] cq, input logic [31:0] cr);
    eq.delete();
    er.delete();
    for (int dq = -n; dq <= n; dq++) begin
      int lo, hi;
      lo = (-dq - n > -n) ? -dq - n : -n;
      hi = (-dq + n < n) ? -dq + n : n;
      for (int dr = lo; dr <= hi; dr++) begin
        eq.push_back(cq + 32'(dq));
        er.push_back(cr + 32'(dr));
      end
    end
  endfunction

  task automatic walk(input vec_t v);
    int n, k, cyc, lim;
    bit stalled, got_last;
    logic [129:0] held;
    logic [31:0] es, fq, fr, lq, lr;
    lim = v.b ? 2 : 1023;
    n = (v.rad > lim) ? lim : v.rad;
    build(n, v.cq, v.cr);
    sel_b = v.b;
    @(negedge clk);
    radius = 16'(v.rad);
    center_q = v.cq;
    center_r = v.cr;
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("latency_valid", m_valid, 1);
    chk("busy_run", m_busy, 1);
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    got_last = 1'b0;
    fq = '0; fr = '0; lq = '0; lr = '0;
    while (!got_last && cyc < 4000) begin
      if (stalled) chk("hold", {m_q, m_r, m_s, m_idx, m_first, m_last}, held);
      chk("valid_no_bubble", m_valid, 1);
      out_ready = ($urandom_range(0, 99) < v.pct);
      if (m_valid && out_ready) begin
        if (k < eq.size()) begin
          es = -eq[k] - er[k];
          chk("beat_q", m_q, eq[k]);
          chk("beat_r", m_r, er[k]);
          chk("beat_s", m_s, es);
          chk("beat_idx", m_idx, k);
          chk("beat_first", m_first, k == 0);
          chk("beat_last", m_last, k == eq.size() - 1);
        end
        if (k == 0) begin
          fq = m_q;
          fr = m_r;
        end
        lq = m_q;
        lr = m_r;
        got_last = m_last;
        k++;
      end
      stalled = m_valid && !out_ready;
      held = {m_q, m_r, m_s, m_idx, m_first, m_last};
      @(negedge clk);
      cyc++;
    end
    chk("walk_timeout", cyc < 4000, 1);
    chk("count", k, v.cnt);
    chk("count_fn", k, hex_range_count(32'(n)));
    chk("first_coord", {fq, fr}, {v.fq, v.fr});
    chk("last_coord", {lq, lr}, {v.lq, v.lr});
    chk("done_pulse", {m_done, m_valid, m_busy}, 3'b100);
    @(negedge clk);
    chk("done_once", m_done, 0);
  endtask

  initial begin
    vec_t vecs[7];
    int cyc;
    vecs[0] = '{0,     32'd5,          -32'sd2, 100, 1,  32'd5,          -32'sd2, 32'd5,          -32'sd2, 1'b0};
    vecs[1] = '{1,     32'd2,          32'd3,   100, 7,  32'd1,          32'd3,   32'd3,          32'd3,   1'b0};
    vecs[2] = '{3,     32'd0,          32'd0,   50,  37, -32'sd3,        32'd0,   32'd3,          32'd0,   1'b0};
    vecs[3] = '{2,     -32'sd10,       32'd7,   100, 19, -32'sd12,       32'd7,   -32'sd8,        32'd7,   1'b0};
    vecs[4] = '{1,     32'h7FFF_FFFF,  32'd0,   100, 7,  32'h7FFF_FFFE,  32'd0,   32'h8000_0000,  32'd0,   1'b0};
    vecs[5] = '{4,     32'd0,          32'd0,   30,  61, -32'sd4,        32'd0,   32'd4,          32'd0,   1'b0};
    vecs[6] = '{65535, 32'd0,          32'd0,   100, 19, -32'sd2,        32'd0,   32'd2,          32'd0,   1'b1};

    #1;
    chk("reset_a", {a_valid, a_busy, a_q, a_r, a_s, a_first, a_last, a_idx, a_done}, 0);
    chk("reset_b", {b_valid, b_busy, b_q, b_r, b_s, b_first, b_last, b_idx, b_done}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) walk(vecs[i]);

    // abort after beat 5 with a simultaneous restart; a mid-walk start must be ignored
    sel_b = 1'b0;
    build(4, 32'd0, 32'd0);
    @(negedge clk);
    radius = 16'd4;
    center_q = '0;
    center_r = '0;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("ab_idx", a_idx, i);
      chk("ab_q", a_q, eq[i]);
      chk("ab_r", a_r, er[i]);
      if (i == 2) begin
        start = 1'b1;
        center_q = 32'd100;
      end
      if (i == 3) start = 1'b0;
      if (i == 5) begin
        abort = 1'b1;
        start = 1'b1;
        radius = 16'd0;
        center_q = 32'd9;
        center_r = 32'd9;
      end
      @(negedge clk);
    end
    chk("ab_idle", {a_valid, a_busy, a_done}, 3'b000);
    abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("ab_restart", {a_valid, a_first, a_last, a_done}, 4'b1110);
    chk("ab_restart_idx", a_idx, 0);
    chk("ab_restart_qr", {a_q, a_r}, {32'd9, 32'd9});
    @(negedge clk);
    chk("ab_restart_done", {a_done, a_valid}, 2'b10);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    walk(vecs[6]);

    // asynchronous reset in the middle of a clamped walk
    sel_b = 1'b1;
    @(negedge clk);
    radius = 16'hFFFF;
    center_q = 32'd1;
    center_r = 32'd1;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (b_idx != 32'd10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_wait", cyc < 100, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_b", {b_valid, b_busy, b_q, b_r, b_s, b_first, b_last, b_idx, b_done}, 0);
    chk("rst_async_a", {a_valid, a_busy, a_q, a_r, a_s, a_first, a_last, a_idx, a_done}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", {b_done, b_valid, b_busy}, 3'b000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
